// File: rtl/counter_pkg.sv
// Shared helpers for the JK-based modulo counters.
package counter_pkg;

  // Load value limited to the largest legal count.
  function automatic int unsigned clamp_load(input int unsigned val, input int unsigned maxv);
    return (val > maxv) ? maxv : val;
  endfunction

endpackage

// File: rtl/jk_stage.sv
// Single-bit JK register with asynchronous active-high preset to PRESET_VAL.
module jk_stage #(
  parameter logic PRESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic preset,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;
  logic q_d;

  // JK characteristic equation: hold, reset, set, toggle.
  always_comb begin
    q_d = q_q;
    unique case ({j, k})
      2'b01:   q_d = 1'b0;
      2'b10:   q_d = 1'b1;
      2'b11:   q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  // Storage bit; preset forces the reset value regardless of clk.
  always_ff @(posedge clk or posedge preset) begin
    if (preset) q_q <= PRESET_VAL;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter: next state -> JK excitation -> one JK stage per bit.
module jk_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             preset,
  input  logic             sclr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

  // Reject widths the 32-bit load clamp cannot cover and moduli outside 2..2^WIDTH.
  if (WIDTH < 1 || WIDTH > 31 || MODULUS < 2 || 64'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_param
    $error("jk_mod_counter: illegal WIDTH/MODULUS combination");
  end

  logic [WIDTH-1:0] n_c;
  logic [WIDTH-1:0] j_c;
  logic [WIDTH-1:0] k_c;
  logic             wrap_d;
  logic             wrap_q;

  // Desired next count; out-of-range states step to the wrap target.
  always_comb begin
    n_c = q;
    if (sclr) begin
      n_c = '0;
    end else if (load) begin
      n_c = WIDTH'(clamp_load(32'(d), MODULUS - 1));
    end else if (en && up) begin
      n_c = (q >= MAXV) ? '0 : q + WIDTH'(1);
    end else if (en) begin
      n_c = (q == '0 || q > MAXV) ? MAXV : q - WIDTH'(1);
    end
  end

  // Excitation: set bits that must rise, reset bits that must fall, never toggle.
  always_comb begin
    j_c = n_c & ~q;
    k_c = ~n_c & q;
  end

  // Terminal count gated only by en; wrap only when the count actually steps.
  always_comb begin
    tc     = en & ((up & (q == MAXV)) | (~up & (q == '0)));
    wrap_d = tc & ~sclr & ~load;
  end

  // One-cycle wrap pulse; preset cancels any pending pulse.
  always_ff @(posedge clk or posedge preset) begin
    if (preset) wrap_q <= 1'b0;
    else        wrap_q <= wrap_d;
  end

  assign wrap = wrap_q;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_stage
    jk_stage #(
      .PRESET_VAL(MAXV[i])
    ) u_stage (
      .clk   (clk),
      .preset(preset),
      .j     (j_c[i]),
      .k     (k_c[i]),
      .q     (q[i])
    );
  end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed bench for jk_mod_counter: default (4/10) instance and a 3/8 full-range instance.
module tb_jk_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic       a_preset, a_sclr, a_load, a_en, a_up;
  logic [3:0] a_d, a_q;
  logic       a_tc, a_wrap;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut_a (
    .clk(clk), .preset(a_preset), .sclr(a_sclr), .load(a_load), .d(a_d),
    .en(a_en), .up(a_up), .q(a_q), .tc(a_tc), .wrap(a_wrap)
  );

  // Full-range instance
  logic       b_preset, b_sclr, b_load, b_en, b_up;
  logic [2:0] b_d, b_q;
  logic       b_tc, b_wrap;

  jk_mod_counter #(.WIDTH(3), .MODULUS(8)) dut_b (
    .clk(clk), .preset(b_preset), .sclr(b_sclr), .load(b_load), .d(b_d),
    .en(b_en), .up(b_up), .q(b_q), .tc(b_tc), .wrap(b_wrap)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // J and K must never both be high on any bit of either instance.
  always @(negedge clk) begin
    chk("jk_toggle_a", 32'(dut_a.j_c & dut_a.k_c), 32'd0);
    chk("jk_toggle_b", 32'(dut_b.j_c & dut_b.k_c), 32'd0);
  end

  typedef struct {
    logic       sclr;
    logic       load;
    logic       en;
    logic       up;
    logic [3:0] d;
    logic       exp_tc;   // before the edge
    logic [3:0] exp_q;    // after the edge
    logic       exp_wrap; // after the edge
  } vec_t;

  vec_t vecs[13];
  int   wrap_cnt;

  initial begin
    // sclr load en up d  tc q  wrap
    vecs[0]  = '{0, 0, 1, 1, 4'd0,  1, 4'd0, 1}; // 9 -> 0 wraps
    vecs[1]  = '{0, 0, 1, 1, 4'd0,  0, 4'd1, 0};
    vecs[2]  = '{0, 0, 1, 1, 4'd0,  0, 4'd2, 0};
    vecs[3]  = '{0, 1, 0, 1, 4'd13, 0, 4'd9, 0}; // clamp
    vecs[4]  = '{0, 1, 0, 1, 4'd7,  0, 4'd7, 0};
    vecs[5]  = '{0, 1, 0, 1, 4'd0,  0, 4'd0, 0};
    vecs[6]  = '{0, 0, 1, 0, 4'd0,  1, 4'd9, 1}; // down wrap 0 -> 9
    vecs[7]  = '{0, 0, 1, 0, 4'd0,  0, 4'd8, 0};
    vecs[8]  = '{0, 0, 0, 0, 4'd0,  0, 4'd8, 0}; // hold
    vecs[9]  = '{0, 1, 0, 1, 4'd9,  0, 4'd9, 0};
    vecs[10] = '{1, 1, 1, 1, 4'd5,  1, 4'd0, 0}; // sclr wins, no wrap
    vecs[11] = '{0, 1, 1, 0, 4'd3,  1, 4'd3, 0}; // load overrides down wrap
    vecs[12] = '{0, 0, 1, 1, 4'd0,  0, 4'd4, 0};

    a_preset = 1'b1; a_sclr = 1'b0; a_load = 1'b0; a_en = 1'b0; a_up = 1'b1; a_d = '0;
    b_preset = 1'b1; b_sclr = 1'b0; b_load = 1'b0; b_en = 1'b0; b_up = 1'b1; b_d = '0;

    #2;
    chk("preset_q", 32'(a_q), 32'd9);
    chk("preset_wrap", 32'(a_wrap), 32'd0);

    // Preset held across an edge with en high: state stays at MAXV.
    a_en = 1'b1;
    @(posedge clk); #1;
    chk("preset_hold_q", 32'(a_q), 32'd9);
    a_preset = 1'b0;
    b_preset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      a_sclr = vecs[i].sclr; a_load = vecs[i].load; a_en = vecs[i].en;
      a_up   = vecs[i].up;   a_d    = vecs[i].d;
      #1;
      chk($sformatf("v%0d_tc", i), 32'(a_tc), 32'(vecs[i].exp_tc));
      @(posedge clk); #1;
      chk($sformatf("v%0d_q", i), 32'(a_q), 32'(vecs[i].exp_q));
      chk($sformatf("v%0d_wrap", i), 32'(a_wrap), 32'(vecs[i].exp_wrap));
    end

    // Async preset between edges at q=4 with en high.
    a_sclr = 1'b0; a_load = 1'b0; a_en = 1'b1; a_up = 1'b1;
    a_preset = 1'b1;
    #2;
    chk("async_preset_q", 32'(a_q), 32'd9);
    chk("async_preset_wrap", 32'(a_wrap), 32'd0);
    a_preset = 1'b0;
    @(posedge clk); #1;
    chk("post_preset_q", 32'(a_q), 32'd0);
    chk("post_preset_wrap", 32'(a_wrap), 32'd1);

    // Pending wrap pulse is cancelled by preset mid-cycle.
    a_preset = 1'b1;
    #2;
    chk("cancel_wrap", 32'(a_wrap), 32'd0);
    chk("cancel_q", 32'(a_q), 32'd9);
    a_preset = 1'b0;
    a_en = 1'b0;
    @(posedge clk); #1;
    chk("idle_q", 32'(a_q), 32'd9);
    chk("idle_wrap", 32'(a_wrap), 32'd0);

    // Full-range rollover on the 3-bit, modulus-8 instance.
    b_preset = 1'b1;
    #2;
    chk("b_preset_q", 32'(b_q), 32'd7);
    b_preset = 1'b0;
    b_en = 1'b1; b_up = 1'b1;
    wrap_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      chk($sformatf("b_step%0d_q", k), 32'(b_q), 32'(k % 8));
      chk($sformatf("b_step%0d_wrap", k), 32'(b_wrap), 32'((k % 8) == 0));
      if (b_wrap) wrap_cnt++;
    end
    chk("b_wrap_count", 32'(wrap_cnt), 32'd2);
    b_en = 1'b0;

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
